math_expr_arbiter: RTL and testbench
====================================

MATH_EXPR_ARBITER -- requirements
Module: math_expr_arbiter

Interface
REQ-001 Parameter W, default 16, sets the operand and result width in bits.
REQ-002 Parameter N, default 4, sets the number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 8, sets the maximum WAIT cycles before abort (>=4).
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester request level; held with its operands until gnt.
REQ-007 op_a, op_b, op_c, op_d  input  N*W each  signed per-requester operands; requester i occupies bits [i*W +: W].
REQ-008 gnt  output  N  one-hot, one-cycle pulse marking operand capture for the selected requester.
REQ-009 resp_valid  output  N  one-hot, one-cycle pulse marking result delivery to the owning requester.
REQ-010 resp_q  output  W  signed quotient, valid while resp_valid is nonzero.
REQ-011 resp_rmd  output  1  remainder bit, valid while resp_valid is nonzero.
REQ-012 resp_err  output  1  timeout flag, valid while resp_valid is nonzero.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL instantiate exactly one math_expression core (width W) and share it among all N requesters.
REQ-015 The core SHALL compute numerator = ((a-b)*(3c+1) - 4d), truncated to W bits; q = numerator >>> 1 (arithmetic shift); rmd = numerator[0].
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE with req!=0, the FSM SHALL select the first set req bit, searching upward from rr_ptr with wrap, register it as sel, and go to ISSUE.
REQ-018 In IDLE with req==0, the FSM SHALL stay in IDLE; req is re-evaluated every IDLE cycle, and a request dropped before gnt is not served.
REQ-019 ISSUE SHALL last exactly one cycle: gnt[sel]=1, core start=1, core operands = requester sel's operands; next state WAIT.
REQ-020 In WAIT, the cycle counter SHALL increment; on core valid=1, the block SHALL capture core q/rmd into the response registers and go to DONE with resp_err=0.
REQ-021 If the counter reaches TIMEOUT-1 without core valid, the block SHALL pulse core reset for one cycle, load resp_q=0, resp_rmd=0, resp_err=1, and go to DONE.
REQ-022 DONE SHALL last exactly one cycle: resp_valid[sel]=1 with the registered results; rr_ptr <= (sel+1) mod N; next state IDLE.
REQ-023 Nominal latency: req sampled in cycle 0 -> gnt/start in cycle 1 -> core valid in cycle 3 -> resp_valid in cycle 4; throughput is one operation per 5 cycles.
REQ-024 The core start input SHALL be high only in ISSUE, which guarantees a single-cycle valid from the core.
REQ-025 gnt, resp_valid and core start SHALL each be registered, glitch-free and at most one-hot.
REQ-026 A req asserted while busy SHALL wait without loss until the next IDLE arbitration.
REQ-027 With all requesters continuously requesting, grants SHALL rotate 0,1,...,N-1,0; no requester waits more than N operations.

Reset
REQ-028 On reset, the FSM SHALL enter IDLE with rr_ptr=0, sel=0 and counter=0.
REQ-029 On reset, gnt, resp_valid, resp_q, resp_rmd, resp_err and busy SHALL all be 0.
REQ-030 On reset, the core SHALL be reset (core reset = reset OR abort pulse).
REQ-031 Reset mid-operation SHALL discard the in-flight operation with no resp_valid; the first cycle after reset is IDLE.

Verification
REQ-032 req=0001, requester 0 a=5 b=2 c=1 d=1 -> gnt=0001 in cycle 1; resp_valid=0001 in cycle 4 with q=4, rmd=0, err=0.
REQ-033 requester 2 a=0 b=1 c=0 d=0 -> resp_q=-1 (0xFFFF), rmd=1; a=0 b=1 c=1 d=0 -> q=-2, rmd=0.
REQ-034 req=1111 held continuously -> gnt order 0001,0010,0100,1000,0001; successive gnts 5 cycles apart.
REQ-035 Core valid forced low (fault injection), TIMEOUT=8 -> resp_valid[sel]=1 with err=1 and q=0; the next request completes normally.
REQ-036 reset asserted in WAIT -> no resp_valid, busy=0 in the next cycle; a new req=0100 is granted first (rr_ptr=0 search order from bit 0 still selects bit 2).
REQ-037 req bit dropped in the IDLE cycle before gnt -> no gnt for it; another pending requester is granted instead.

Source files
------------

// File: rtl/math_expr_arbiter.sv
// math_expr_arbiter: one shared math_expression core serving N
// requesters through round-robin arbitration with timeout abort.

// Two-stage pipelined core: q/rmd of ((a-b)*(3c+1) - 4d) mod 2^W.
module math_expression #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic signed [W-1:0] d,
   output logic                valid,
   output logic signed [W-1:0] q,
   output logic                rmd
);
   logic signed [W-1:0] diff;
   logic signed [W-1:0] c3;
   logic signed [W-1:0] d4;
   logic signed [W-1:0] num;
   logic                v1;

   // stage 1: operand difference, 3c+1 and 4d
   always_ff @(posedge clk) begin
      if (reset) begin
         v1   <= 1'b0;
         diff <= '0;
         c3   <= '0;
         d4   <= '0;
      end else begin
         v1 <= start;
         if (start) begin
            diff <= a - b;
            c3   <= (c <<< 1) + c + W'(1);
            d4   <= d <<< 2;
         end
      end
   end

   // stage 2: product minus 4d, single-cycle valid
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         num   <= '0;
      end else begin
         valid <= v1;
         if (v1) begin
            num <= diff * c3 - d4;
         end
      end
   end

   assign q   = num >>> 1;
   assign rmd = num[0];
endmodule

module math_expr_arbiter #(
   parameter int W       = 16,
   parameter int N       = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        req,
   input  logic [N*W-1:0]      op_a,
   input  logic [N*W-1:0]      op_b,
   input  logic [N*W-1:0]      op_c,
   input  logic [N*W-1:0]      op_d,
   output logic [N-1:0]        gnt,
   output logic [N-1:0]        resp_valid,
   output logic signed [W-1:0] resp_q,
   output logic                resp_rmd,
   output logic                resp_err,
   output logic                busy
);
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [PW-1:0]       sel;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       pick;
   logic [PW-1:0]       sel_inc;
   logic                found;
   logic [CW-1:0]       cnt;
   logic                abort;
   logic                abort_q;
   logic                start;
   logic                core_rst;
   logic                core_valid;
   logic                core_rmd;
   logic signed [W-1:0] core_q;
   logic signed [W-1:0] a_sel;
   logic signed [W-1:0] b_sel;
   logic signed [W-1:0] c_sel;
   logic signed [W-1:0] d_sel;

   // first set req bit at or above rr_ptr, wrapping around
   always_comb begin
      int j;
      j     = 0;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   // operands of the owning requester feed the core
   always_comb begin
      a_sel = op_a[int'(sel)*W +: W];
      b_sel = op_b[int'(sel)*W +: W];
      c_sel = op_c[int'(sel)*W +: W];
      d_sel = op_d[int'(sel)*W +: W];
   end

   assign sel_inc  = (int'(sel) == N - 1) ? '0 : sel + PW'(1);
   assign core_rst = reset | abort_q;
   assign busy     = (state != IDLE);

   math_expression #(.W(W)) u_core (
      .clk   (clk),
      .reset (core_rst),
      .start (start),
      .a     (a_sel),
      .b     (b_sel),
      .c     (c_sel),
      .d     (d_sel),
      .valid (core_valid),
      .q     (core_q),
      .rmd   (core_rmd)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state and timeout abort decision
   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      unique case (state)
         IDLE:  if (found) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (core_valid) begin
               state_nx = DONE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // registered grant, start, response and pointer bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         sel        <= '0;
         rr_ptr     <= '0;
         cnt        <= '0;
         gnt        <= '0;
         start      <= 1'b0;
         resp_valid <= '0;
         resp_q     <= '0;
         resp_rmd   <= 1'b0;
         resp_err   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         gnt        <= '0;
         start      <= 1'b0;
         resp_valid <= '0;
         abort_q    <= abort;
         cnt        <= (state == WAIT) ? cnt + CW'(1) : '0;
         if (state == IDLE && found) begin
            sel   <= pick;
            gnt   <= ONE << pick;
            start <= 1'b1;
         end
         if (state == WAIT && core_valid) begin
            resp_q     <= core_q;
            resp_rmd   <= core_rmd;
            resp_err   <= 1'b0;
            resp_valid <= ONE << sel;
         end else if (abort) begin
            resp_q     <= '0;
            resp_rmd   <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= ONE << sel;
         end
         if (state == DONE) rr_ptr <= sel_inc;
      end
   end
endmodule

// File: tb/tb_math_expr_arbiter.sv
// tb_math_expr_arbiter: directed checks of arbitration order,
// latency, results, timeout abort and reset behaviour.

module tb_math_expr_arbiter;
   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0;
   logic [N*W-1:0] op_b = '0;
   logic [N*W-1:0] op_c = '0;
   logic [N*W-1:0] op_d = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   resp_valid;
   logic [W-1:0]   resp_q;
   logic           resp_rmd;
   logic           resp_err;
   logic           busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   math_expr_arbiter #(.W(W), .N(N), .TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_c       (op_c),
      .op_d       (op_d),
      .gnt        (gnt),
      .resp_valid (resp_valid),
      .resp_q     (resp_q),
      .resp_rmd   (resp_rmd),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic set_ops(input int i, input int a, input int b,
                          input int c, input int d);
      op_a[i*W +: W] = W'(a);
      op_b[i*W +: W] = W'(b);
      op_c[i*W +: W] = W'(c);
      op_d[i*W +: W] = W'(d);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] mask,
                         input logic [3:0] exp_g, input logic [15:0] eq,
                         input logic er, input logic ee, input int lat);
      int n;
      req = mask;
      @(negedge clk);
      check({tag, ".gnt"}, gnt, exp_g);
      req = '0;
      n = 0;
      while (resp_valid == '0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".lat"}, n, lat);
      check({tag, ".rv"}, resp_valid, exp_g);
      check({tag, ".q"}, resp_q, eq);
      check({tag, ".rmd"}, resp_rmd, er);
      check({tag, ".err"}, resp_err, ee);
      @(negedge clk);
      check({tag, ".idle"}, busy, 1'b0);
   endtask

   logic [3:0] g [5];
   int         t [5];
   logic [3:0] rot_exp [5];

   initial begin
      int k;
      int cyc;
      int hits;
      rot_exp[0] = 4'b0001;
      rot_exp[1] = 4'b0010;
      rot_exp[2] = 4'b0100;
      rot_exp[3] = 4'b1000;
      rot_exp[4] = 4'b0001;

      repeat (3) @(negedge clk);
      check("rst.gnt", gnt, 0);
      check("rst.rv", resp_valid, 0);
      check("rst.busy", busy, 0);
      check("rst.q", resp_q, 0);
      check("rst.err", resp_err, 0);
      check("rst.rmd", resp_rmd, 0);
      reset = 1'b0;

      set_ops(0, 5, 2, 1, 1);
      set_ops(1, 5, 2, 1, 1);
      set_ops(2, 0, 1, 0, 0);
      set_ops(3, 7, 2, 2, 3);

      run_op("r0", 4'b0001, 4'b0001, 16'h0004, 1'b0, 1'b0, 3);
      run_op("r2a", 4'b0100, 4'b0100, 16'hFFFF, 1'b1, 1'b0, 3);
      set_ops(2, 0, 1, 1, 0);
      run_op("r2b", 4'b0100, 4'b0100, 16'hFFFE, 1'b0, 1'b0, 3);
      run_op("r3", 4'b1000, 4'b1000, 16'd11, 1'b1, 1'b0, 3);

      do_reset();
      req = 4'hF;
      k = 0;
      cyc = 0;
      while (k < 5 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (gnt != '0) begin
            g[k] = gnt;
            t[k] = cyc;
            k++;
         end
      end
      req = '0;
      check("rot.count", k, 5);
      for (int i = 0; i < k; i++) check("rot.gnt", g[i], rot_exp[i]);
      for (int i = 1; i < k; i++) check("rot.gap", t[i] - t[i-1], 5);
      cyc = 0;
      while (busy && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("rot.drain", busy, 0);

      force dut.core_valid = 1'b0;
      run_op("tmo", 4'b0010, 4'b0010, 16'h0000, 1'b0, 1'b1, 9);
      release dut.core_valid;
      run_op("post", 4'b0010, 4'b0010, 16'h0004, 1'b0, 1'b0, 3);

      req = 4'b0001;
      @(negedge clk);
      check("mid.gnt", gnt, 4'b0001);
      req = '0;
      @(negedge clk);
      check("mid.busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("mid.rbusy", busy, 1'b0);
      check("mid.rrv", resp_valid, 0);
      reset = 1'b0;
      hits = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid != '0) hits++;
      end
      check("mid.norv", hits, 0);
      run_op("mid.rr", 4'b1001, 4'b0001, 16'h0004, 1'b0, 1'b0, 3);
      run_op("mid.r2", 4'b0100, 4'b0100, 16'hFFFE, 1'b0, 1'b0, 3);

      req = 4'b0001;
      @(negedge clk);
      check("drop.g0", gnt, 4'b0001);
      req = 4'b1010;
      cyc = 0;
      while (resp_valid == '0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check("drop.rv0", resp_valid, 4'b0001);
      @(negedge clk);
      check("drop.idle", busy, 1'b0);
      req = 4'b1000;
      @(negedge clk);
      check("drop.gnt", gnt, 4'b1000);
      req = '0;
      cyc = 0;
      while (resp_valid == '0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check("drop.rv", resp_valid, 4'b1000);
      check("drop.q", resp_q, 16'd11);
      check("drop.rmd", resp_rmd, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
